mips_instr_loader: RTL
======================

# mips_instr_loader

Instruction-side memory for the Harvard CPU, filled by a byte-stream loader. The block is the write/responder end of the CPU instruction-fetch port. It accepts a program as a stream of bytes, packs them into 32-bit words, and stores them from the reset vector upward. It holds the CPU in reset until loading completes, then serves `instr_address` fetches combinationally. It replaces hand-coded instruction lookup in benches and sits between the loader source (bench or UART front-end) and `mips_cpu_harvard`.

## Interface
Parameters:
- `DEPTH_WORDS`, 256: storage words; power of two, 4..4096.
- `BASE_ADDR`, 32'hBFC00000: byte address of word 0; word-aligned.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `load_valid`  in  1  byte present on `load_byte`.
- `load_byte`  in  8  program byte.
- `load_last`  in  1  qualifies the final byte of the program; sampled with `load_valid`.
- `load_ready`  out  1  block accepts a byte this cycle.
- `load_restart`  in  1  single-cycle request to reload; honoured only in DONE.
- `load_done`  out  1  program resident.
- `load_overflow`  out  1  stream exceeded `DEPTH_WORDS`; sticky until reset or restart.
- `words_loaded`  out  $clog2(DEPTH_WORDS)+1  count of words written.
- `cpu_reset`  out  1  active-high reset for `mips_cpu_harvard`.
- `instr_address`  in  32  CPU fetch address.
- `instr_readdata`  out  32  fetched word.
- `fetch_fault`  out  1  current fetch is misaligned, below `BASE_ADDR`, or at/after `words_loaded`.

## Operation
- States: LOAD, DONE.
  - On reset, the block is in LOAD with `words_loaded`=0, byte count 0, assembly register 0, `load_overflow`=0.
- LOAD:
  - `load_ready`=1. A byte is accepted when `load_valid && load_ready`.
  - Stream order is big-endian: byte 0 goes to [31:24], byte 1 to [23:16], byte 2 to [15:8], byte 3 to [7:0].
  - On the 4th accepted byte, the assembled word is written to `mem[words_loaded]` and `words_loaded` increments.
  - `load_last` on byte k<3 zero-pads the remaining low bytes, writes the word, and moves to DONE.
  - `load_last` on byte 3 writes the word and moves to DONE.
  - A write that makes `words_loaded`==`DEPTH_WORDS` moves to DONE even without `load_last`. Any further `load_valid` seen in DONE before `load_restart` sets `load_overflow`, and the byte is dropped.
  - `load_last` with byte count 0 and no data is impossible: `load_last` only qualifies an accepted byte.
- DONE:
  - `load_ready`=0, `load_done`=1, `cpu_reset`=0.
  - `load_restart` returns the block to LOAD and clears `words_loaded`, byte count, and `load_overflow`. It also reasserts `cpu_reset`. Memory contents are not cleared.
- Fetch (combinational):
  - Word index = (`instr_address` − `BASE_ADDR`) >> 2.
  - If the address is aligned, ≥`BASE_ADDR`, and index < `words_loaded`, `instr_readdata` = `mem[index]`.
  - Otherwise `instr_readdata`=0 (NOP) and `fetch_fault`=1.
  - Address 0, the CPU halt target, therefore reads 0 with `fetch_fault`=1.
- Subtraction is 32-bit unsigned. An address below `BASE_ADDR` is detected by compare before subtraction, never by wrap.

## Timing
- Reset values: `load_ready`=1, `load_done`=0, `load_overflow`=0, `words_loaded`=0, `cpu_reset`=1. `fetch_fault`=1 for all addresses, since nothing is loaded.
- `load_ready` is a decode of state only, with no dependence on `load_valid`.
- A word write, `words_loaded` increment, and state change all take effect at the accepting edge.
  - `load_done` rises and `cpu_reset` falls at that same edge; both are registered.
  - A fetch in the next cycle sees the new word.
- `load_restart` takes effect at the next edge; `cpu_reset`=1 from that edge.
- `reset_n` low mid-stream aborts the partial word immediately; no write occurs.
- Simultaneous `load_restart` and `load_valid` in DONE: the restart wins and the byte is not accepted (`load_ready` was 0).

## Structure
- Package `mips_loader_pkg`:
  - state enum `loader_state_t` {LOAD, DONE};
  - `RESET_VECTOR` = 32'hBFC00000;
  - `NOP_WORD` = 32'h0.
- Sub-module `mips_word_assembler`:
  - 2-bit byte counter, shift register, and zero-pad-on-last logic;
  - outputs `word_valid` / `word`.
- The top level holds the FSM, the write pointer, the memory array, and the fetch decode.

## Test plan
- Stream 28 bytes encoding 24 84 FF FF, 00 04 24 00, …, 24 00 00 00 with `load_last` on the final byte, then run the CPU:
  - `words_loaded`=7;
  - fetch 0xBFC00000 → 0x2484FFFF;
  - fetch 0xBFC00010 → 0x00A4102A;
  - `register_v0`==1 at fetch of address 0.
- 6 bytes AA BB CC DD 11 22 with `load_last` on 22:
  - `words_loaded`=2;
  - word 1 = 0x11220000;
  - `load_done` rises at the edge accepting 22.
- `DEPTH_WORDS`=4, stream 20 bytes without `load_last`:
  - DONE after byte 16;
  - bytes 17–20 dropped;
  - `load_overflow`=1;
  - word 3 holds bytes 13–16.
- After a 7-word load, fetch 0xBFC00002, 0xBFC0001C, 0x0, and 0xBFBFFFFC:
  - each → `instr_readdata`=0, `fetch_fault`=1.
- Pulse `reset_n` low after byte 2 of word 3:
  - all outputs return to reset values;
  - reloading 1 word gives `words_loaded`=1.
- In DONE, pulse `load_restart` together with `load_valid`:
  - `cpu_reset`=1 at the next edge;
  - the concurrent byte is not accepted;
  - the next accepted byte lands in [31:24] of word 0.

Source files
------------

// File: rtl/mips_loader_pkg.sv
// Shared types and constants for the instruction-side loader memory.
package mips_loader_pkg;

    typedef enum logic {
        LOAD = 1'b0,
        DONE = 1'b1
    } loader_state_t;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] NOP_WORD     = 32'h0000_0000;

endpackage

// File: rtl/mips_word_assembler.sv
// Packs a big-endian byte stream into 32-bit words; a final byte in a
// partial word zero-pads the remaining low bytes.
module mips_word_assembler (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  load_byte_in,
    input  logic        last,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  r_cnt;
    logic [31:0] r_asm;
    logic [31:0] w_placed;

    // Place the incoming byte in its lane and merge with the bytes held so far.
    always_comb begin
        w_placed = 32'h0000_0000;
        case (r_cnt)
            2'd0:    w_placed = {load_byte_in, 24'h00_0000};
            2'd1:    w_placed = {8'h00, load_byte_in, 16'h0000};
            2'd2:    w_placed = {16'h0000, load_byte_in, 8'h00};
            2'd3:    w_placed = {24'h00_0000, load_byte_in};
            default: w_placed = 32'h0000_0000;
        endcase
        word       = r_asm | w_placed;
        word_valid = accept && (last || (r_cnt == 2'd3));
    end

    // Byte counter and partial-word register; emptied whenever a word leaves.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= 2'd0;
            r_asm <= 32'h0000_0000;
        end else if (clear || word_valid) begin
            r_cnt <= 2'd0;
            r_asm <= 32'h0000_0000;
        end else if (accept) begin
            r_cnt <= r_cnt + 2'd1;
            r_asm <= word;
        end else begin
            r_cnt <= r_cnt;
            r_asm <= r_asm;
        end
    end

endmodule

// File: rtl/mips_instr_loader.sv
// Instruction memory filled from a byte stream; holds the CPU in reset
// until the program is resident, then answers fetches combinationally.
module mips_instr_loader
    import mips_loader_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = RESET_VECTOR
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         load_valid,
    input  logic [7:0]                   load_byte,
    input  logic                         load_last,
    output logic                         load_ready,
    input  logic                         load_restart,
    output logic                         load_done,
    output logic                         load_overflow,
    output logic [$clog2(DEPTH_WORDS):0] words_loaded,
    output logic                         cpu_reset,
    input  logic [31:0]                  instr_address,
    output logic [31:0]                  instr_readdata,
    output logic                         fetch_fault
);

    localparam int AW = $clog2(DEPTH_WORDS);

    loader_state_t r_state;
    loader_state_t w_state_nxt;
    logic [AW:0]   r_words_loaded;
    logic [AW:0]   w_words_nxt;
    logic [AW:0]   w_words_inc;
    logic          r_overflow;
    logic          w_overflow_nxt;
    logic          w_accept;
    logic          w_clear;
    logic          w_word_valid;
    logic [31:0]   w_word;
    logic [31:0]   w_idx;
    logic          w_hit;
    logic [31:0]   r_mem [DEPTH_WORDS];

    assign load_ready    = (r_state == LOAD);
    assign load_done     = (r_state == DONE);
    assign cpu_reset     = (r_state == LOAD);
    assign load_overflow = r_overflow;
    assign words_loaded  = r_words_loaded;
    assign w_accept      = load_valid && load_ready;
    assign w_clear       = (r_state == DONE) && load_restart;
    assign w_words_inc   = r_words_loaded + {{AW{1'b0}}, 1'b1};

    mips_word_assembler u_asm (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (w_clear),
        .accept       (w_accept),
        .load_byte_in (load_byte),
        .last         (load_last),
        .word_valid   (w_word_valid),
        .word         (w_word)
    );

    // Next-state logic: finish on last byte or full memory; restart or flag overflow in DONE.
    always_comb begin
        w_state_nxt    = r_state;
        w_words_nxt    = r_words_loaded;
        w_overflow_nxt = r_overflow;
        case (r_state)
            LOAD: begin
                if (w_word_valid) begin
                    w_words_nxt = w_words_inc;
                    if (load_last || (w_words_inc == (AW+1)'(DEPTH_WORDS))) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = LOAD;
                    end
                end else begin
                    w_state_nxt = LOAD;
                end
            end
            DONE: begin
                if (load_restart) begin
                    w_state_nxt    = LOAD;
                    w_words_nxt    = '0;
                    w_overflow_nxt = 1'b0;
                end else if (load_valid) begin
                    w_overflow_nxt = 1'b1;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            default: begin
                w_state_nxt = LOAD;
            end
        endcase
    end

    // State, write pointer and sticky overflow registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= LOAD;
            r_words_loaded <= '0;
            r_overflow     <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_words_loaded <= w_words_nxt;
            r_overflow     <= w_overflow_nxt;
        end
    end

    // Program storage; contents survive reset and restart.
    always_ff @(posedge clk) begin
        if (w_word_valid) begin
            r_mem[r_words_loaded[AW-1:0]] <= w_word;
        end
    end

    // Fetch decode: below-base is caught by compare so the subtraction never wraps into range.
    always_comb begin
        w_idx          = (instr_address - BASE_ADDR) >> 2;
        w_hit          = (instr_address >= BASE_ADDR) &&
                         (instr_address[1:0] == 2'b00) &&
                         (w_idx < 32'(r_words_loaded));
        instr_readdata = NOP_WORD;
        fetch_fault    = 1'b1;
        if (w_hit) begin
            instr_readdata = r_mem[w_idx[AW-1:0]];
            fetch_fault    = 1'b0;
        end else begin
            instr_readdata = NOP_WORD;
            fetch_fault    = 1'b1;
        end
    end

endmodule
